// File: rtl/au_result_router_if.sv
// ---------------------------------------------------------------------------
// au_result_router_if
// Bundles the result-router traffic into one interface: the AU-side input
// handshake and the seven per-destination output handshakes.
//   in_valid  : AU result valid
//   in_ready  : router can accept a result this cycle
//   in_sel    : destination index of the result
//   in_data   : result data
//   out_valid : one-hot (or zero) valid, bit i addresses destination i
//   out_ready : per-destination ready
//   out_data  : head-entry data, shared by all destinations
// Modports:
//   master : the environment (AU producer plus result consumers)
//   slave  : the router itself
// ---------------------------------------------------------------------------
interface au_result_router_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_DEST = 7,
  parameter int SEL_W    = 3
);
  logic                in_valid;
  logic                in_ready;
  logic [SEL_W-1:0]    in_sel;
  logic [DATA_W-1:0]   in_data;
  logic [NUM_DEST-1:0] out_valid;
  logic [NUM_DEST-1:0] out_ready;
  logic [DATA_W-1:0]   out_data;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/au_result_router.sv
// ---------------------------------------------------------------------------
// au_result_router
// Return path of the AU: accepts one tagged result per cycle and delivers it
// to exactly one of NUM_DEST consumers through a small in-order FIFO, so AU
// issue is decoupled from consumer back-pressure.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous reset, active-high
//   bus        : au_result_router_if.slave (input and output handshakes)
//   err_badsel : sticky flag, an out-of-range select was received
//   fifo_count : current FIFO occupancy
// ---------------------------------------------------------------------------
module au_result_router #(
  parameter int DATA_W   = 32,
  parameter int NUM_DEST = 7,
  parameter int SEL_W    = 3,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  au_result_router_if.slave  bus,
  output logic               err_badsel,
  output logic [CNT_W-1:0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]   data_mem [DEPTH];
  logic [SEL_W-1:0]    sel_mem  [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  logic                in_ready;
  logic                accept;
  logic                sel_ok;
  logic                push;
  logic                pop;
  logic                not_empty;
  logic [SEL_W-1:0]    head_sel;
  logic [NUM_DEST-1:0] out_valid;
  logic [DATA_W-1:0]   out_data;

  // Ready looks only at the registered count, so a full FIFO refuses input
  // even in a cycle where the head is being popped.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign accept    = bus.in_valid && in_ready;
  assign sel_ok    = (bus.in_sel < SEL_W'(NUM_DEST));
  // A bad select is consumed but never stored.
  assign push      = accept && sel_ok;
  assign not_empty = (count != '0);
  assign head_sel  = sel_mem[rd_ptr];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    out_valid = '0;
    out_data  = '0;
    if (not_empty) begin
      out_valid = NUM_DEST'(1) << head_sel;
      out_data  = data_mem[rd_ptr];
    end
  end

  // Only the addressed destination's ready can complete the handshake.
  assign pop = |(out_valid & bus.out_ready);

  // NOTE: the storage array is deliberately not reset; the count and
  // pointers alone decide which entries are live, so stale contents are
  // never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.in_data;
      sel_mem[wr_ptr]  <= bus.in_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_badsel <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (accept && !sel_ok) err_badsel <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign fifo_count    = count;

endmodule
